alu_shift_sequencer: RTL and testbench
======================================

Name: alu_shift_sequencer

Overview:
- Multi-cycle controller that performs multibit shift/rotate instructions (SHL/SHR/SAR/ROL/ROR/RCL/RCR) by driving the combinational ALU one single-bit step per clock.
- Each step feeds the ALU result and flags back into the ALU inputs.
- Sits between microcode/execution control and the ALU for the shift path.
- Presents a start/done handshake and registered result/flags to the execution unit.

Parameters:
- COUNT_BITS, 5, width of shift count; count is masked to COUNT_BITS bits (80186 semantics: count & 0x1f).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- op  input  `MC_ALUOp_t_BITS  ALU operation to iterate (one of the seven shift/rotate ops)
- is_8_bit  input  1  byte operation
- operand  input  16  value to shift
- count  input  COUNT_BITS  shift count
- flags_in  input  16  flags at start
- ready  output  1  idle, can accept start
- done  output  1  single-cycle completion pulse
- result  output  16  registered final value
- flags_out  output  16  registered final flags
- alu_a  output  16  to ALU a (accumulator register)
- alu_op  output  `MC_ALUOp_t_BITS  to ALU op (latched op)
- alu_is_8_bit  output  1  to ALU is_8_bit (latched)
- alu_flags_in  output  16  to ALU flags_in (flag register)
- alu_multibit_shift  output  1  constant 0
- alu_shift_count  output  5  constant 1
- alu_out  input  16  ALU out[15:0]
- alu_flags_out  input  16  ALU flags_out

Behaviour:
- States: IDLE, RUN, DONE. Reset (async, any state, including mid-RUN) -> IDLE.
- Reset values: ready=1, done=0, result=0, flags_out=0, accumulator=0, flag reg=0, remaining=0, op/is_8_bit latches=0.
- IDLE, start=1:
  - Latch operand->acc, flags_in->flag reg, op, is_8_bit, remaining=count.
  - If masked count==0, or op is not a shift/rotate op: go to DONE (pass-through; result=operand, flags unchanged). Otherwise go to RUN.
- RUN, each cycle:
  - acc<=alu_out (upper byte zeroed when is_8_bit), flag reg<=alu_flags_out, remaining<=remaining-1.
  - When remaining==1 at the clock edge, go to DONE.
- DONE (one cycle):
  - done=1; result=acc and flags_out=flag reg, both as registered values.
  - Next state IDLE. result/flags_out hold until the next completion.
- Latency: done is high exactly N+1 cycles after the start edge for an effective count of N; pass-through cases take 1 cycle.
- ready=1 only in IDLE. start in RUN/DONE is ignored; its inputs are not latched.
- The start inputs (operand/count/etc.) may change after acceptance without effect.
- Count 16..31 on 16-bit, and 8..31 on 8-bit, iterate the full count. No reduction modulo width; rotate results therefore follow the naturally.
- The sequencer does not interpret flags; it accepts per-step ALU flag results, including OF from the final step.
- alu_multibit_shift is always 0; alu_shift_count is always 1; the ALU busy output is unused.

Test Plan:
- SHL 16-bit operand=0x0001, count=4, flags_in=0x0000 -> done in cycle 5 after start, result=0x0010, CF=0, ready low cycles 1-5.
- SHR 8-bit operand=0x0081, count=1 -> done cycle 2, result=0x0040, CF=1.
- ROL 16-bit operand=0x8001, count=17 -> 17 RUN cycles, done cycle 18, result=0x0003, CF=1.
- Count=0 (and count=0x20 with COUNT_BITS=5 truncated to 0), operand=0x1234, flags_in=0x0ACD -> done cycle 1, result=0x1234, flags_out=0x0ACD, alu values never captured.
- Second start pulsed during RUN with different operand -> ignored; first result unaffected. A start in the cycle after done is accepted.
- RCL 16-bit, CF=1, operand=0x0000, count=3, reset asserted in cycle 2 -> immediate IDLE, ready=1, done never pulses, result/flags_out=0. A fresh start afterwards completes normally (result=0x0004, CF=0).

Source files
------------

// File: rtl/alu_shift_sequencer.sv
// Iterates a single-bit ALU shift/rotate once per clock to build multibit SHL/SHR/SAR/ROL/ROR/RCL/RCR.
// Latency count+1 cycles (1 for count 0 / non-shift ops); start is honoured only while ready is high.
`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif

module alu_shift_sequencer #(
  parameter int COUNT_BITS = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [`MC_ALUOp_t_BITS-1:0] op,
  input  logic                        is_8_bit,
  input  logic [15:0]                 operand,
  input  logic [COUNT_BITS-1:0]       count,
  input  logic [15:0]                 flags_in,
  output logic                        ready,
  output logic                        done,
  output logic [15:0]                 result,
  output logic [15:0]                 flags_out,
  output logic [15:0]                 alu_a,
  output logic [`MC_ALUOp_t_BITS-1:0] alu_op,
  output logic                        alu_is_8_bit,
  output logic [15:0]                 alu_flags_in,
  output logic                        alu_multibit_shift,
  output logic [4:0]                  alu_shift_count,
  input  logic [15:0]                 alu_out,
  input  logic [15:0]                 alu_flags_out
);

  localparam logic [`MC_ALUOp_t_BITS-1:0] OP_SHL = `MC_ALUOp_t_BITS'(10);
  localparam logic [`MC_ALUOp_t_BITS-1:0] OP_SHR = `MC_ALUOp_t_BITS'(11);
  localparam logic [`MC_ALUOp_t_BITS-1:0] OP_SAR = `MC_ALUOp_t_BITS'(12);
  localparam logic [`MC_ALUOp_t_BITS-1:0] OP_ROL = `MC_ALUOp_t_BITS'(13);
  localparam logic [`MC_ALUOp_t_BITS-1:0] OP_ROR = `MC_ALUOp_t_BITS'(14);
  localparam logic [`MC_ALUOp_t_BITS-1:0] OP_RCL = `MC_ALUOp_t_BITS'(15);
  localparam logic [`MC_ALUOp_t_BITS-1:0] OP_RCR = `MC_ALUOp_t_BITS'(16);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                        state;
  logic [15:0]                   acc;
  logic [15:0]                   flag_reg;
  logic [COUNT_BITS-1:0]         remaining;
  logic [`MC_ALUOp_t_BITS-1:0]   op_q;
  logic                          is_8_bit_q;
  logic                          is_shift_op;
  logic [15:0]                   step_val;

  always_comb begin
    is_shift_op = 1'b0;
    case (op)
      OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR: is_shift_op = 1'b1;
      default: is_shift_op = 1'b0;
    endcase
  end

  // Byte ops leave the ALU's upper byte undefined, so it is discarded every step.
  assign step_val = is_8_bit_q ? {8'h00, alu_out[7:0]} : alu_out;

  assign alu_a              = acc;
  assign alu_op             = op_q;
  assign alu_is_8_bit       = is_8_bit_q;
  assign alu_flags_in       = flag_reg;
  assign alu_multibit_shift = 1'b0;
  assign alu_shift_count    = 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      result     <= '0;
      flags_out  <= '0;
      acc        <= '0;
      flag_reg   <= '0;
      remaining  <= '0;
      op_q       <= '0;
      is_8_bit_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc        <= operand;
            flag_reg   <= flags_in;
            op_q       <= op;
            is_8_bit_q <= is_8_bit;
            remaining  <= count;
            ready      <= 1'b0;
            if (count == '0 || !is_shift_op) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              result    <= operand;
              flags_out <= flags_in;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc       <= step_val;
          flag_reg  <= alu_flags_out;
          remaining <= remaining - COUNT_BITS'(1);
          // Publish on the last step so done and result appear together.
          if (remaining == COUNT_BITS'(1)) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            result    <= step_val;
            flags_out <= alu_flags_out;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: plays the single-bit ALU and compares against closed-form shift/rotate results.
`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif

module tb_alu_shift_sequencer;

  localparam logic [4:0] OP_SHL = 5'd10;
  localparam logic [4:0] OP_SHR = 5'd11;
  localparam logic [4:0] OP_SAR = 5'd12;
  localparam logic [4:0] OP_ROL = 5'd13;
  localparam logic [4:0] OP_ROR = 5'd14;
  localparam logic [4:0] OP_RCL = 5'd15;
  localparam logic [4:0] OP_RCR = 5'd16;
  localparam logic [4:0] OP_ADD = 5'd3;

  logic        clk, reset, start, is_8_bit;
  logic [4:0]  op, count;
  logic [15:0] operand, flags_in;
  logic        ready, done, alu_is_8_bit, alu_multibit_shift;
  logic [15:0] result, flags_out, alu_a, alu_flags_in, alu_out, alu_flags_out;
  logic [4:0]  alu_op, alu_shift_count;

  int total = 0;
  int bad = 0;

  alu_shift_sequencer #(.COUNT_BITS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .is_8_bit(is_8_bit),
    .operand(operand), .count(count), .flags_in(flags_in),
    .ready(ready), .done(done), .result(result), .flags_out(flags_out),
    .alu_a(alu_a), .alu_op(alu_op), .alu_is_8_bit(alu_is_8_bit),
    .alu_flags_in(alu_flags_in), .alu_multibit_shift(alu_multibit_shift),
    .alu_shift_count(alu_shift_count), .alu_out(alu_out), .alu_flags_out(alu_flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-step ALU; byte results carry junk in the upper byte on purpose.
  function automatic logic [31:0] alu_step(input logic [4:0] o, input logic b8,
                                           input logic [15:0] a0, input logic [15:0] f);
    int w;
    longint a, r, m;
    logic cf, of;
    logic [15:0] nf, res;
    w = b8 ? 8 : 16;
    m = (longint'(1) << w) - 1;
    a = longint'(a0) & m;
    r = a; cf = f[0]; of = f[11];
    case (o)
      OP_SHL: begin r = (a << 1) & m; cf = a[w-1]; of = r[w-1] ^ cf; end
      OP_SHR: begin r = a >> 1; cf = a[0]; of = a[w-1]; end
      OP_SAR: begin r = (a >> 1) | (a & (longint'(1) << (w-1))); cf = a[0]; of = 1'b0; end
      OP_ROL: begin r = ((a << 1) | longint'(a[w-1])) & m; cf = a[w-1]; of = r[w-1] ^ cf; end
      OP_ROR: begin r = (a >> 1) | (longint'(a[0]) << (w-1)); cf = a[0]; of = r[w-1] ^ r[w-2]; end
      OP_RCL: begin r = ((a << 1) | longint'(f[0])) & m; cf = a[w-1]; of = r[w-1] ^ cf; end
      OP_RCR: begin r = (a >> 1) | (longint'(f[0]) << (w-1)); cf = a[0]; of = r[w-1] ^ r[w-2]; end
      default: ;
    endcase
    nf = f; nf[0] = cf; nf[11] = of;
    res = r[15:0];
    if (b8) res[15:8] = 8'hA5;
    return {nf, res};
  endfunction

  assign {alu_flags_out, alu_out} = alu_step(alu_op, alu_is_8_bit, alu_a, alu_flags_in);

  // Whole-instruction reference: closed-form shift/rotate over the full count.
  task automatic model(input logic [4:0] o, input logic b8, input logic [15:0] v0,
                       input logic [4:0] n5, input logic [15:0] fl,
                       output logic [15:0] er, output logic [15:0] ef, output int lat);
    int w, n, k, ww;
    longint v, m, r, t, sv, x, xx, mw;
    logic cf, of;
    n = int'(n5);
    w = b8 ? 8 : 16;
    m = (longint'(1) << w) - 1;
    v = longint'(v0) & m;
    if (n == 0 || o < OP_SHL || o > OP_RCR) begin
      er = v0; ef = fl; lat = 1;
      return;
    end
    ww = w + 1;
    mw = (longint'(1) << ww) - 1;
    x = (longint'(fl[0]) << w) | v;
    r = 0; cf = 1'b0; of = 1'b0;
    case (o)
      OP_SHL: begin r = (v << n) & m; t = (v << n) >> w; cf = t[0]; of = r[w-1] ^ cf; end
      OP_SHR: begin r = v >> n; t = v >> (n - 1); cf = t[0]; of = t[w-1]; end
      OP_SAR: begin
        sv = (v ^ (longint'(1) << (w-1))) - (longint'(1) << (w-1));
        r = (sv >>> n) & m; t = sv >>> (n - 1); cf = t[0]; of = 1'b0;
      end
      OP_ROL: begin k = n % w; r = ((v << k) | (v >> (w - k))) & m; cf = r[0]; of = r[w-1] ^ cf; end
      OP_ROR: begin k = n % w; r = ((v >> k) | (v << (w - k))) & m; cf = r[w-1]; of = r[w-1] ^ r[w-2]; end
      OP_RCL: begin
        k = n % ww; xx = ((x << k) | (x >> (ww - k))) & mw;
        r = xx & m; cf = xx[w]; of = r[w-1] ^ cf;
      end
      default: begin
        k = n % ww; xx = ((x >> k) | (x << (ww - k))) & mw;
        r = xx & m; cf = xx[w]; of = r[w-1] ^ r[w-2];
      end
    endcase
    er = r[15:0];
    ef = fl; ef[0] = cf; ef[11] = of;
    lat = n + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; start is presented immediately so back-to-back ops are exercised.
  task automatic run_op(input string name, input logic [4:0] o, input logic b8,
                        input logic [15:0] opnd, input logic [4:0] cnt, input logic [15:0] fl,
                        input logic [15:0] er, input logic [15:0] ef, input int lat, input bit glitch);
    int cyc, rdy_hi;
    start = 1'b1; op = o; is_8_bit = b8; operand = opnd; count = cnt; flags_in = fl;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; is_8_bit = ~b8; operand = ~opnd; count = ~cnt; flags_in = ~fl;
    cyc = 1; rdy_hi = 0;
    while (!done && cyc < 80) begin
      if (ready) rdy_hi++;
      if (glitch && cyc == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (ready) rdy_hi++;
    check({name, " latency"}, cyc, lat);
    check({name, " result"}, result, er);
    check({name, " flags"}, flags_out, ef);
    check({name, " ready_busy"}, rdy_hi, 0);
    @(posedge clk); #1;
    check({name, " done_pulse"}, {done, ready}, 2'b01);
  endtask

  typedef struct {
    logic [4:0]  o;
    logic        b8;
    logic [15:0] opnd;
    int          cnt;
    logic [15:0] fl;
    logic [15:0] er;
    logic [15:0] ef;
    int          lat;
    bit          glitch;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [15:0] er, ef, v;
    logic [4:0] o, c;
    logic b8;
    int lat, seen;

    vecs[0]  = '{OP_SHL, 1'b0, 16'h0001,  4, 16'h0000, 16'h0010, 16'h0000,  5, 1'b0};
    vecs[1]  = '{OP_SHL, 1'b0, 16'h0001,  4, 16'h0000, 16'h0010, 16'h0000,  5, 1'b1};
    vecs[2]  = '{OP_SHR, 1'b1, 16'h0081,  1, 16'h0000, 16'h0040, 16'h0801,  2, 1'b0};
    vecs[3]  = '{OP_ROL, 1'b0, 16'h8001, 17, 16'h0000, 16'h0003, 16'h0801, 18, 1'b0};
    vecs[4]  = '{OP_SHL, 1'b0, 16'h1234,  0, 16'h0ACD, 16'h1234, 16'h0ACD,  1, 1'b0};
    vecs[5]  = '{OP_SHL, 1'b0, 16'h1234, 32, 16'h0ACD, 16'h1234, 16'h0ACD,  1, 1'b0};
    vecs[6]  = '{OP_ADD, 1'b0, 16'h5678,  5, 16'h0ACD, 16'h5678, 16'h0ACD,  1, 1'b0};
    vecs[7]  = '{OP_SAR, 1'b1, 16'h0080,  9, 16'h0000, 16'h00FF, 16'h0001, 10, 1'b0};
    vecs[8]  = '{OP_RCR, 1'b1, 16'h0001,  9, 16'h0000, 16'h0001, 16'h0000, 10, 1'b0};
    vecs[9]  = '{OP_SHL, 1'b0, 16'hFFFF, 16, 16'h0000, 16'h0000, 16'h0801, 17, 1'b0};
    vecs[10] = '{OP_ROR, 1'b0, 16'h0001,  1, 16'h0000, 16'h8000, 16'h0801,  2, 1'b0};

    reset = 1'b1; start = 1'b0; op = '0; is_8_bit = 1'b0;
    operand = '0; count = '0; flags_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {ready, done, result, flags_out}, {2'b10, 16'h0000, 16'h0000});
    check("reset regs", {alu_a, alu_flags_in, alu_op, alu_is_8_bit}, '0);
    check("alu constants", {alu_multibit_shift, alu_shift_count}, {1'b0, 5'd1});
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      c = vecs[i].cnt[4:0];
      run_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].b8, vecs[i].opnd, c, vecs[i].fl,
             vecs[i].er, vecs[i].ef, vecs[i].lat, vecs[i].glitch);
    end

    // Reset in the middle of an RCL must abandon it without a done pulse.
    start = 1'b1; op = OP_RCL; is_8_bit = 1'b0; operand = 16'h0000; count = 5'd3; flags_in = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrun reset outputs", {ready, done, result, flags_out}, {2'b10, 16'h0000, 16'h0000});
    check("midrun reset regs", {alu_a, alu_flags_in}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || !ready) seen++;
      @(posedge clk); #1;
    end
    check("midrun no done", seen, 0);
    run_op("rcl after reset", OP_RCL, 1'b0, 16'h0000, 5'd3, 16'h0001, 16'h0004, 16'h0000, 4, 1'b0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0: o = OP_SHL; 1: o = OP_SHR; 2: o = OP_SAR; 3: o = OP_ROL;
        4: o = OP_ROR; 5: o = OP_RCL; 6: o = OP_RCR; default: o = OP_ADD;
      endcase
      b8 = 1'($urandom_range(0, 1));
      v  = 16'($urandom);
      c  = 5'($urandom_range(0, 31));
      ef = 16'($urandom);
      model(o, b8, v, c, ef, er, flags_in, lat);
      run_op($sformatf("rand%0d op=%0d b8=%0d v=%h n=%0d", i, o, b8, v, c),
             o, b8, v, c, ef, er, flags_in, lat, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
